// File: rtl/mem_stage_sram_ctrl.sv
// Memory pipeline stage with a multi-cycle word-addressed SRAM model and MEM/WB register.
// Optional address range/alignment checking is enabled by defining MEM_ADDR_CHECK_EN.
module mem_stage_sram_ctrl #(
  parameter int DEPTH       = 64,
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest_in,
  output logic        freeze,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_read_value,
  output logic [3:0]  dest_out,
  output logic        addr_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stall, capture, bubble, done;

  logic             req;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             illegal;
  logic             we;
  logic [31:0]      rd_data;

  logic [31:0]      mem [DEPTH];

  assign req    = mem_r_en_in | mem_w_en_in;
  assign offset = alu_result_in - 32'(ADDR_BASE);
  assign idx    = offset[IDX_W+1:2];

`ifdef MEM_ADDR_CHECK_EN
  logic unused_offset_lsb;
  assign unused_offset_lsb = ^offset[1:0];
  // Modulo subtraction makes addresses below the base wrap to huge offsets.
  assign illegal = (offset >= 32'(4 * DEPTH)) || (alu_result_in[1:0] != 2'b00);
`else
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    capture   = 1'b0;
    bubble    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          state_nxt = ACCESS;
          cnt_nxt   = CNT_LOAD;
        end else begin
          capture = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is withdrawn immediately when reset abandons an access.
  assign freeze = stall & ~rst;

  assign we      = done & mem_w_en_in & ~illegal & ~rst;
  assign rd_data = mem[idx];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= val_rm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      alu_result_out <= '0;
      mem_read_value <= '0;
      dest_out       <= '0;
      addr_err       <= 1'b0;
    end else if (capture) begin
      wb_en_out      <= wb_en_in;
      mem_r_en_out   <= mem_r_en_in;
      alu_result_out <= alu_result_in;
      mem_read_value <= '0;
      dest_out       <= dest_in;
      addr_err       <= 1'b0;
    end else if (bubble) begin
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      addr_err       <= 1'b0;
    end else if (done) begin
      wb_en_out      <= wb_en_in & ~illegal;
      mem_r_en_out   <= mem_r_en_in;
      alu_result_out <= alu_result_in;
      // Read data is sampled before the write lands, giving pre-write contents.
      mem_read_value <= (mem_r_en_in & ~illegal) ? rd_data : 32'h0;
      dest_out       <= dest_in;
      addr_err       <= illegal;
    end
  end

endmodule
